// File: rtl/shift_register_pkg.sv
// -----------------------------------------------------------------------------
// shift_register_pkg
// Purpose : Shared definitions for the parametrised LED shift register.
//           Holds the operation-mode encodings and the default timing
//           constants used by shift_register_param and key_event.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package shift_register_pkg;

   // Operation modes selected by the mode switches; 2'b11 behaves as shift.
   localparam logic [1:0] MODE_SHIFT  = 2'b00;
   localparam logic [1:0] MODE_ROTATE = 2'b01;
   localparam logic [1:0] MODE_ARITH  = 2'b10;

   // Default key-path constants.
   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_REPEAT_DELAY  = 25000000;
   localparam int DEF_REPEAT_PERIOD = 5000000;

endpackage : shift_register_pkg

// File: rtl/shift_register_param_key_event.sv
// -----------------------------------------------------------------------------
// key_event
// Purpose : Turns one active-low, asynchronous push-button into single-cycle
//           event pulses. A SYNC_STAGES-flop synchroniser feeds a history flop;
//           a falling edge of the synchronised key is a press event. With
//           REPEAT_EN != 0 a counter adds repeat events REPEAT_DELAY cycles
//           after the press and then every REPEAT_PERIOD cycles while held.
// Ports   : i_clk    - system clock
//           i_rst_n  - asynchronous active-low reset
//           i_key_n  - raw active-low key, asynchronous to i_clk
//           o_event  - single-cycle event pulse (press or repeat)
// -----------------------------------------------------------------------------
module key_event #(
   parameter int SYNC_STAGES   = 2,
   parameter int REPEAT_EN     = 0,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 5000000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_key_n,
   output logic o_event
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [SYNC_STAGES-1:0] r_fill;
   logic                   r_hist;
   logic                   r_armed;
   logic                   w_key_n;
   logic                   w_press;

   assign w_key_n = r_sync[SYNC_STAGES-1];

   // The synchroniser resets to "released", so right after reset its output
   // is not a real sample. r_fill tracks when the chain holds genuine key
   // samples; the key must then be seen released before presses are armed,
   // which stops a key held through reset from producing an event.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync  <= '1;
         r_fill  <= '0;
         r_hist  <= 1'b1;
         r_armed <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_key_n};
         r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
         r_hist <= w_key_n;
         if (r_fill[SYNC_STAGES-1] && w_key_n) begin
            r_armed <= 1'b1;
         end
      end
   end

   assign w_press = r_armed & r_hist & ~w_key_n;

   generate
      if (REPEAT_EN != 0) begin : g_repeat
         localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
         localparam int CNT_W   = $clog2(MAX_CNT) + 1;

         logic [CNT_W-1:0] r_cnt;
         logic             r_active;
         logic             r_first;
         logic             w_fire;

         // r_cnt holds the number of cycles since the last press/repeat event.
         assign w_fire = r_active & ~w_key_n &
                         (r_cnt == (r_first ? CNT_W'(REPEAT_DELAY) : CNT_W'(REPEAT_PERIOD)));

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_cnt    <= '0;
               r_active <= 1'b0;
               r_first  <= 1'b1;
            end else if (w_key_n) begin
               r_cnt    <= '0;
               r_active <= 1'b0;
               r_first  <= 1'b1;
            end else if (w_press) begin
               r_cnt    <= CNT_W'(1);
               r_active <= 1'b1;
               r_first  <= 1'b1;
            end else if (w_fire) begin
               r_cnt   <= CNT_W'(1);
               r_first <= 1'b0;
            end else if (r_active) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end

         assign o_event = w_press | w_fire;
      end else begin : g_no_repeat
         assign o_event = w_press;
      end
   endgenerate

endmodule : key_event

// File: rtl/shift_register_param.sv
// -----------------------------------------------------------------------------
// shift_register_param
// Purpose : WIDTH-bit LED shift register driven by active-low push-buttons.
//           Left/right keys shift, rotate or arithmetic-shift depending on
//           mode; the load key copies load_data. carry_out holds the last bit
//           shifted or rotated out, for cascading.
// Config  : define SHIFT_REGISTER_PARAM_AUTO_REPEAT_EN to enable auto-repeat
//           on ls_key/rs_key (never on ld_key).
// Ports   : clk        - system clock
//           rst_key    - asynchronous active-low reset
//           ls_key     - left-operation key, active-low, asynchronous
//           rs_key     - right-operation key, active-low, asynchronous
//           ld_key     - parallel-load key, active-low, asynchronous
//           mode[1:0]  - 00 shift, 01 rotate, 10 arithmetic, 11 as 00
//           ls_bit     - fill bit into the LSB on a left shift
//           rs_bit     - fill bit into the MSB on a right shift
//           load_data  - parallel load value
//           LEDS       - register contents
//           carry_out  - last bit shifted/rotated out
// -----------------------------------------------------------------------------
module shift_register_param
   import shift_register_pkg::*;
#(
   parameter int               WIDTH         = 8,
   parameter int               SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
   parameter int               REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int               REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic             clk,
   input  logic             rst_key,
   input  logic             ls_key,
   input  logic             rs_key,
   input  logic             ld_key,
   input  logic [1:0]       mode,
   input  logic             ls_bit,
   input  logic             rs_bit,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] LEDS,
   output logic             carry_out
);

`ifdef SHIFT_REGISTER_PARAM_AUTO_REPEAT_EN
   localparam int LR_REPEAT_EN = 1;
`else
   localparam int LR_REPEAT_EN = 0;
`endif

   logic             w_ls_evt;
   logic             w_rs_evt;
   logic             w_ld_evt;
   logic             w_lfill;
   logic             w_rfill;
   logic [WIDTH-1:0] w_leds_nxt;
   logic             w_carry_nxt;
   logic [WIDTH-1:0] r_leds;
   logic             r_carry;

   key_event #(
      .SYNC_STAGES  (SYNC_STAGES),
      .REPEAT_EN    (LR_REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
   ) u_ls_key (
      .i_clk  (clk),
      .i_rst_n(rst_key),
      .i_key_n(ls_key),
      .o_event(w_ls_evt)
   );

   key_event #(
      .SYNC_STAGES  (SYNC_STAGES),
      .REPEAT_EN    (LR_REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
   ) u_rs_key (
      .i_clk  (clk),
      .i_rst_n(rst_key),
      .i_key_n(rs_key),
      .o_event(w_rs_evt)
   );

   key_event #(
      .SYNC_STAGES  (SYNC_STAGES),
      .REPEAT_EN    (0),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
   ) u_ld_key (
      .i_clk  (clk),
      .i_rst_n(rst_key),
      .i_key_n(ld_key),
      .o_event(w_ld_evt)
   );

   // Fill bits per mode; unused encoding 2'b11 falls through to plain shift.
   always_comb begin
      w_lfill = ls_bit;
      w_rfill = rs_bit;
      case (mode)
         MODE_ROTATE: begin
            w_lfill = r_leds[WIDTH-1];
            w_rfill = r_leds[0];
         end
         MODE_ARITH: begin
            w_lfill = 1'b0;
            w_rfill = r_leds[WIDTH-1];
         end
         default: begin
            w_lfill = ls_bit;
            w_rfill = rs_bit;
         end
      endcase
   end

   // Load has priority; left and right together cancel each other.
   always_comb begin
      w_leds_nxt  = r_leds;
      w_carry_nxt = r_carry;
      if (w_ld_evt) begin
         w_leds_nxt = load_data;
      end else if (w_ls_evt && !w_rs_evt) begin
         w_leds_nxt  = {r_leds[WIDTH-2:0], w_lfill};
         w_carry_nxt = r_leds[WIDTH-1];
      end else if (w_rs_evt && !w_ls_evt) begin
         w_leds_nxt  = {w_rfill, r_leds[WIDTH-1:1]};
         w_carry_nxt = r_leds[0];
      end
   end

   always_ff @(posedge clk or negedge rst_key) begin
      if (!rst_key) begin
         r_leds  <= RESET_VALUE;
         r_carry <= 1'b0;
      end else begin
         r_leds  <= w_leds_nxt;
         r_carry <= w_carry_nxt;
      end
   end

   assign LEDS      = r_leds;
   assign carry_out = r_carry;

endmodule : shift_register_param

// File: tb/tb_shift_register_param.sv
// -----------------------------------------------------------------------------
// tb_shift_register_param
// Purpose : Self-checking bench for shift_register_param (WIDTH=8,
//           SYNC_STAGES=2, REPEAT_DELAY=10, REPEAT_PERIOD=4). Directed steps
//           followed by random key operations checked against an arithmetic
//           model of the register. Honours SHIFT_REGISTER_PARAM_AUTO_REPEAT_EN.
// -----------------------------------------------------------------------------
module tb_shift_register_param;

`ifdef SHIFT_REGISTER_PARAM_AUTO_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_key;
   logic       ls_key;
   logic       rs_key;
   logic       ld_key;
   logic [1:0] mode;
   logic       ls_bit;
   logic       rs_bit;
   logic [7:0] load_data;
   logic [7:0] LEDS;
   logic       carry_out;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state.
   logic [7:0] m_r;
   logic       m_c;

   shift_register_param #(
      .WIDTH        (8),
      .SYNC_STAGES  (2),
      .RESET_VALUE  (8'h00),
      .REPEAT_DELAY (10),
      .REPEAT_PERIOD(4)
   ) dut (
      .clk      (clk),
      .rst_key  (rst_key),
      .ls_key   (ls_key),
      .rs_key   (rs_key),
      .ld_key   (ld_key),
      .mode     (mode),
      .ls_bit   (ls_bit),
      .rs_bit   (rs_bit),
      .load_data(load_data),
      .LEDS     (LEDS),
      .carry_out(carry_out)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model of one event: plain integer arithmetic on the register value.
   function automatic void model_apply(input bit l, input bit r, input bit d);
      int v;
      int fill;
      v = int'(m_r);
      if (d) begin
         m_r = load_data;
      end else if (l && !r) begin
         if (mode == 2'd1)      fill = v / 128;
         else if (mode == 2'd2) fill = 0;
         else                   fill = int'(ls_bit);
         m_c = (v / 128) != 0;
         m_r = 8'((v * 2 + fill) % 256);
      end else if (r && !l) begin
         if (mode == 2'd1)      fill = v % 2;
         else if (mode == 2'd2) fill = v / 128;
         else                   fill = int'(rs_bit);
         m_c = (v % 2) != 0;
         m_r = 8'(v / 2 + fill * 128);
      end
   endfunction

   task automatic press(input bit l, input bit r, input bit d, input int hold);
      ls_key = !l;
      rs_key = !r;
      ld_key = !d;
      tick(hold);
      ls_key = 1'b1;
      rs_key = 1'b1;
      ld_key = 1'b1;
      tick(4);
      model_apply(l, r, d);
   endtask

   initial begin
      int unsigned k;
      int          hold;

      rst_key   = 1'b0;
      ls_key    = 1'b1;
      rs_key    = 1'b1;
      ld_key    = 1'b1;
      mode      = 2'd0;
      ls_bit    = 1'b0;
      rs_bit    = 1'b0;
      load_data = 8'h00;
      m_r       = 8'h00;
      m_c       = 1'b0;
      tick(3);
      check("reset_leds", LEDS, 8'h00);
      check("reset_carry", carry_out, 1'b0);

      // Release reset with keys idle: nothing may change.
      rst_key = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_leds", LEDS, 8'h00);
      end
      check("idle_carry", carry_out, 1'b0);

      // Load latency: update on edge 3 after the key goes low, once.
      load_data = 8'hA5;
      ld_key    = 1'b0;
      tick(2);
      check("ld_edge2", LEDS, 8'h00);
      tick();
      check("ld_edge3", LEDS, 8'hA5);
      tick(2);
      ld_key = 1'b1;
      tick(4);
      check("ld_once", LEDS, 8'hA5);
      model_apply(1'b0, 1'b0, 1'b1);

      mode = 2'd0; ls_bit = 1'b1;
      press(1'b1, 1'b0, 1'b0, 4);
      check("shl_leds", LEDS, 8'h4B);
      check("shl_carry", carry_out, 1'b1);
      mode = 2'd1;
      press(1'b0, 1'b1, 1'b0, 4);
      check("ror_leds", LEDS, 8'hA5);
      check("ror_carry", carry_out, 1'b1);
      mode = 2'd2;
      press(1'b0, 1'b1, 1'b0, 4);
      check("asr_leds", LEDS, 8'hD2);
      check("asr_carry", carry_out, 1'b1);

      // Simultaneous events.
      load_data = 8'h81;
      press(1'b0, 1'b0, 1'b1, 4);
      check("ld81_carry_kept", carry_out, 1'b1);
      press(1'b1, 1'b1, 1'b0, 4);
      check("lr_hold_leds", LEDS, 8'h81);
      check("lr_hold_carry", carry_out, 1'b1);
      load_data = 8'h3C;
      press(1'b1, 1'b1, 1'b1, 4);
      check("lrld_leds", LEDS, 8'h3C);

      // Reset during a held key; held key must not fire after release of reset.
      mode = 2'd0; rs_bit = 1'b1;
      rs_key = 1'b0;
      tick(5);
      check("held_pre_rst", LEDS, 8'h9E);
      rst_key = 1'b0;
      #2;
      check("rst_async_leds", LEDS, 8'h00);
      check("rst_async_carry", carry_out, 1'b0);
      tick(2);
      rst_key = 1'b1;
      tick(15);
      check("held_after_rst", LEDS, 8'h00);
      rs_key = 1'b1;
      tick(4);
      check("released_after_rst", LEDS, 8'h00);
      m_r = 8'h00;
      m_c = 1'b0;
      press(1'b0, 1'b1, 1'b0, 4);
      check("repress_leds", LEDS, 8'h80);
      check("repress_carry", carry_out, 1'b0);

      // Long hold in rotate mode: repeats at event offsets 10,14,18,22 if enabled.
      load_data = 8'h01;
      press(1'b0, 1'b0, 1'b1, 4);
      mode   = 2'd1;
      ls_key = 1'b0;
      tick(3);
      check("hold_first", LEDS, 8'h02);
      tick(9);
      check("hold_edge12", LEDS, 8'h02);
      tick();
      check("hold_edge13", LEDS, REP ? 8'h04 : 8'h02);
      tick(12);
      ls_key = 1'b1;
      tick(10);
      check("hold_final", LEDS, REP ? 8'h20 : 8'h02);
      check("hold_carry", carry_out, 1'b0);
      tick(20);
      check("hold_quiet", LEDS, REP ? 8'h20 : 8'h02);
      m_r = REP ? 8'h20 : 8'h02;
      m_c = 1'b0;

      // Random operations against the model.
      for (int n = 0; n < 60; n++) begin
         mode      = 2'($urandom_range(0, 3));
         ls_bit    = 1'($urandom_range(0, 1));
         rs_bit    = 1'($urandom_range(0, 1));
         load_data = 8'($urandom);
         k         = $urandom_range(0, 9);
         hold      = int'($urandom_range(2, 6));
         case (k)
            0, 1, 2: press(1'b1, 1'b0, 1'b0, hold);
            3, 4, 5: press(1'b0, 1'b1, 1'b0, hold);
            6:       press(1'b1, 1'b1, 1'b0, hold);
            7:       press(1'b0, 1'b0, 1'b1, hold);
            default: press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, hold);
         endcase
         check("rand_leds", LEDS, m_r);
         check("rand_carry", carry_out, m_c);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_shift_register_param

// File: doc/shift_register_param.md
Name: shift_register_param

Overview:
- Parametrised successor to the 8-bit button-driven LED shift register.
- Shift width is set by a parameter. Adds rotate, arithmetic and parallel-load operations, plus a registered shifted-out bit for cascading.
- Optional auto-repeat while a key is held.
- Sits between board push-buttons/switches and the LED bank. All keys are active-low.

Parameters:
- WIDTH, 8, register/LED width; legal range 2 and up.
- SYNC_STAGES, 2, synchroniser flops per key input; legal range 2 and up.
- RESET_VALUE, 0, register value after reset; WIDTH bits.
- REPEAT_DELAY, 25000000, cycles from press event to first auto-repeat (AUTO_REPEAT_EN only).
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeats (AUTO_REPEAT_EN only).

Ports:
- clk, in, 1, system clock.
- rst_key, in, 1, asynchronous active-low reset.
- ls_key, in, 1, left-operation button; active-low, asynchronous to clk.
- rs_key, in, 1, right-operation button; active-low, asynchronous to clk.
- ld_key, in, 1, parallel-load button; active-low, asynchronous to clk.
- mode, in, 2, operation mode: 00 shift, 01 rotate, 10 arithmetic, 11 treated as 00.
- ls_bit, in, 1, fill bit entering the LSB on a left shift.
- rs_bit, in, 1, fill bit entering the MSB on a right shift.
- load_data, in, WIDTH, parallel load value.
- LEDS, out, WIDTH, register contents.
- carry_out, out, 1, last bit shifted or rotated out.

Behaviour:
- Reset (rst_key low, asynchronous):
  - register = RESET_VALUE; carry_out = 0.
  - All synchroniser, edge and repeat state forced to the released state (1), so releasing reset never generates a press event.
- Key path, per key:
  - SYNC_STAGES-flop synchroniser, then one history flop.
  - press event = history high and synchronised low (falling edge); single-cycle pulse.
  - Latency: LEDS updates on clock edge SYNC_STAGES+1, counting the first edge that samples the key low as edge 1.
  - A key held low produces no further events unless AUTO_REPEAT_EN is defined. Release produces no event.
- mode, ls_bit, rs_bit and load_data are static switch inputs, sampled unsynchronised on the event cycle; they must be stable around key presses.
- Operations on an event cycle (R = register):
  - load: R = load_data; carry_out unchanged.
  - left, mode 00: R = {R[WIDTH-2:0], ls_bit}; carry_out = R[WIDTH-1].
  - right, mode 00: R = {rs_bit, R[WIDTH-1:1]}; carry_out = R[0].
  - left, mode 01: R = {R[WIDTH-2:0], R[WIDTH-1]}; carry_out = R[WIDTH-1].
  - right, mode 01: R = {R[0], R[WIDTH-1:1]}; carry_out = R[0].
  - left, mode 10: as mode 00 with the fill bit forced to 0.
  - right, mode 10: R = {R[WIDTH-1], R[WIDTH-1:1]} (sign-extending); carry_out = R[0].
- Simultaneous events in one cycle:
  - load wins over everything.
  - left and right together, without load: no operation; R and carry_out hold.
- No event: R and carry_out hold.
- Reset asserted mid-operation (including during a held key or repeat count) aborts immediately. After reset releases, a key still held low generates no event until it is released and pressed again.

Optional Feature:
- Macro: SHIFT_REGISTER_PARAM_AUTO_REPEAT_EN.
- Defined: applies to ls_key and rs_key only, never ld_key.
  - A per-key counter ($clog2 of the larger of REPEAT_DELAY and REPEAT_PERIOD, plus 1 bit) starts on the press event.
  - A repeat event fires REPEAT_DELAY cycles after the press event, then every REPEAT_PERIOD cycles while the synchronised key stays low.
  - The counter clears on release or reset.
  - A repeat event is identical to a press event, including the simultaneity rules.
- Undefined: counters are not instantiated; exactly one event per press.

Decomposition:
- Shared package shift_register_pkg holds:
  - mode encodings MODE_SHIFT=2'b00, MODE_ROTATE=2'b01, MODE_ARITH=2'b10;
  - default constants for SYNC_STAGES, REPEAT_DELAY and REPEAT_PERIOD.
- One sub-module, key_event: synchroniser, edge detect and optional repeat counter.
  - Parameters: SYNC_STAGES, REPEAT_EN, REPEAT_DELAY, REPEAT_PERIOD.
  - Instantiated three times (REPEAT_EN=0 for ld_key).
- Operation mux and register live in the top module.

Test Plan (WIDTH=8, SYNC_STAGES=2, REPEAT_DELAY=10, REPEAT_PERIOD=4):
- Reset, then release rst_key with all keys high -> LEDS=8'h00 and carry_out=0; no change over 20 cycles.
- load_data=8'hA5, pulse ld_key low for 5 cycles -> LEDS=8'hA5 at edge 3 after key low; exactly one update.
- From 8'hA5:
  - mode 00, ls_bit=1, ls_key press -> LEDS=8'h4B, carry_out=1.
  - then mode 01, rs_key press -> LEDS=8'hA5, carry_out=1.
  - then mode 10, rs_key press -> LEDS=8'hD2, carry_out=1.
- ls_key and rs_key falling in the same cycle with LEDS=8'h81 -> LEDS stays 8'h81; ld_key added in the same cycle -> LEDS=load_data.
- Hold rs_key low, then assert rst_key mid-hold; release reset with the key still held -> LEDS=RESET_VALUE; no event until release and re-press.
- AUTO_REPEAT_EN defined, mode 01, LEDS=8'h01, ls_key held 22 cycles after the first event -> events at offsets 0, 10, 14, 18, 22 -> LEDS=8'h20; no events after release.
